// File: rtl/pipe_ctrl_if.sv
// Control bundle between the RV32I datapath and the pipeline sequencing controller.
// The datapath is the master; pipe_ctrl is the slave.
interface pipe_ctrl_if;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_br_taken;
  logic        ex_jump;
  logic        dmem_req;
  logic        dmem_ready;

  logic [2:0]  imm_sel;
  logic        illegal;
  logic [1:0]  pc_sel;
  logic        pc_we;
  logic        ifid_we;
  logic        idex_we;
  logic        if_flush;
  logic        id_flush;
  logic [31:0] stall_cnt;
  logic [31:0] redir_cnt;

  modport master (
    output id_inst, id_valid, ex_valid, ex_rd, ex_is_load, ex_br_taken, ex_jump,
           dmem_req, dmem_ready,
    input  imm_sel, illegal, pc_sel, pc_we, ifid_we, idex_we, if_flush, id_flush,
           stall_cnt, redir_cnt
  );

  modport slave (
    input  id_inst, id_valid, ex_valid, ex_rd, ex_is_load, ex_br_taken, ex_jump,
           dmem_req, dmem_ready,
    output imm_sel, illegal, pc_sel, pc_we, ifid_we, idex_we, if_flush, id_flush,
           stall_cnt, redir_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 3-stage RV32I core: PC/pipeline-register
// enables and flushes, ID immediate-format decode, and stall/redirect counters.
module pipe_ctrl #(
  parameter int unsigned BOOT_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave ctrl
);

  localparam logic [1:0] StBoot    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StMemWait = 2'd2;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [2:0] ImmI = 3'd0;
  localparam logic [2:0] ImmS = 3'd1;
  localparam logic [2:0] ImmB = 3'd2;
  localparam logic [2:0] ImmU = 3'd3;
  localparam logic [2:0] ImmJ = 3'd4;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcRedir  = 2'd1;
  localparam logic [1:0] PcResetV = 2'd2;

  localparam logic [7:0] BootInit = 8'(BOOT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic [2:0] imm_sel;
  logic       illegal;
  logic       rs1_used, rs2_used;
  logic       hazard, redirect;

  logic [1:0] pc_sel;
  logic       pc_we, ifid_we, idex_we, if_flush, id_flush;
  logic       boot_mode, freeze, advance;
  logic       count_stall, count_redir;

  logic unused_inst;
  assign unused_inst = ^{ctrl.id_inst[31:25], ctrl.id_inst[14:7]};

  assign opcode = ctrl.id_inst[6:0];
  assign rs1    = ctrl.id_inst[19:15];
  assign rs2    = ctrl.id_inst[24:20];

  // ID decode: immediate format and which source registers the instruction reads.
  always_comb begin
    imm_sel  = ImmI;
    illegal  = 1'b0;
    rs1_used = 1'b1;
    rs2_used = 1'b0;
    case (opcode)
      OpLoad, OpImm, OpJalr: imm_sel = ImmI;
      OpStore: begin
        imm_sel  = ImmS;
        rs2_used = 1'b1;
      end
      OpBranch: begin
        imm_sel  = ImmB;
        rs2_used = 1'b1;
      end
      OpLui, OpAuipc: begin
        imm_sel  = ImmU;
        rs1_used = 1'b0;
      end
      OpJal: begin
        imm_sel  = ImmJ;
        rs1_used = 1'b0;
      end
      OpReg: rs2_used = 1'b1;
      default: illegal = ctrl.id_valid;
    endcase
  end

  assign hazard = ctrl.ex_valid & ctrl.ex_is_load & (ctrl.ex_rd != 5'd0) & ctrl.id_valid &
                  ((rs1_used & (rs1 == ctrl.ex_rd)) | (rs2_used & (rs2 == ctrl.ex_rd)));

  assign redirect = ctrl.ex_valid & (ctrl.ex_br_taken | ctrl.ex_jump);

  // Sequencing: Mealy outputs from state and inputs, plus next-state/counter enables.
  always_comb begin
    pc_sel      = PcPlus4;
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    boot_mode   = 1'b0;
    freeze      = 1'b0;
    advance     = 1'b0;
    count_stall = 1'b0;
    count_redir = 1'b0;

    case (state_q)
      StBoot: begin
        boot_mode = 1'b1;
        if (boot_cnt_q == 8'd0) begin
          state_d = StRun;
        end else begin
          boot_cnt_d = boot_cnt_q - 8'd1;
        end
      end
      StRun: begin
        if (ctrl.dmem_req && !ctrl.dmem_ready) begin
          freeze  = 1'b1;
          state_d = StMemWait;
        end else begin
          advance = 1'b1;
        end
      end
      StMemWait: begin
        if (!ctrl.dmem_ready) begin
          freeze = 1'b1;
        end else begin
          advance = 1'b1;
          state_d = StRun;
        end
      end
      default: begin
        boot_mode  = 1'b1;
        state_d    = StBoot;
        boot_cnt_d = BootInit;
      end
    endcase

    if (freeze) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      count_stall = 1'b1;
    end

    // Redirect outranks a load-use hazard: the stalled instruction is squashed anyway.
    if (advance) begin
      if (redirect) begin
        pc_sel      = PcRedir;
        if_flush    = 1'b1;
        id_flush    = 1'b1;
        count_redir = 1'b1;
      end else if (hazard) begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        id_flush    = 1'b1;
        count_stall = 1'b1;
      end
    end

    if (boot_mode || rst) begin
      pc_sel      = PcResetV;
      pc_we       = 1'b1;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      if_flush    = 1'b1;
      id_flush    = 1'b1;
      count_stall = 1'b0;
      count_redir = 1'b0;
    end
  end

  assign stall_cnt_d = stall_cnt_q + {31'd0, count_stall};
  assign redir_cnt_d = redir_cnt_q + {31'd0, count_redir};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      boot_cnt_q  <= BootInit;
      stall_cnt_q <= 32'd0;
      redir_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign ctrl.imm_sel   = imm_sel;
  assign ctrl.illegal   = illegal;
  assign ctrl.pc_sel    = pc_sel;
  assign ctrl.pc_we     = pc_we;
  assign ctrl.ifid_we   = ifid_we;
  assign ctrl.idex_we   = idex_we;
  assign ctrl.if_flush  = if_flush;
  assign ctrl.id_flush  = id_flush;
  assign ctrl.stall_cnt = stall_cnt_q;
  assign ctrl.redir_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized self-checking bench for pipe_ctrl against a behavioural model of the
// sequencing rules, preceded by directed scenarios with literal expectations.
module tb_pipe_ctrl;
  localparam int unsigned BootCycles = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.BOOT_CYCLES(BootCycles)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef enum int {MBoot, MRun, MWait} mode_e;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic       pc_we;
    logic       ifid_we;
    logic       idex_we;
    logic       if_flush;
    logic       id_flush;
    logic       stall;
    logic       redir;
    logic       to_wait;
  } exp_t;

  mode_e       m_mode = MBoot;
  int          m_boot_done = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_redir = 32'd0;
  bit          m_ready = 1'b0;

  localparam logic [31:0] AddX1X5X2 = {7'd0, 5'd2, 5'd5, 3'd0, 5'd1, 7'b0110011};
  localparam logic [31:0] LuiX5     = {20'h00028, 5'd5, 7'b0110111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_imm(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b0110111, 7'b0010111: return 3'd3;
      7'b1101111: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic model_is_base(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};
  endfunction

  function automatic logic model_hazard();
    logic [6:0] op;
    logic       uses1, uses2;
    op    = bus.id_inst[6:0];
    uses1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    uses2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (!(bus.ex_valid && bus.ex_is_load && bus.ex_rd != 5'd0 && bus.id_valid)) return 1'b0;
    return (uses1 && bus.id_inst[19:15] == bus.ex_rd) || (uses2 && bus.id_inst[24:20] == bus.ex_rd);
  endfunction

  function automatic exp_t model_ctrl();
    exp_t e;
    logic frozen;
    e = '0;
    if (rst || m_mode == MBoot) begin
      e.pc_sel = 2'd2; e.pc_we = 1'b1; e.if_flush = 1'b1; e.id_flush = 1'b1;
      return e;
    end
    frozen = (m_mode == MRun) ? (bus.dmem_req && !bus.dmem_ready) : !bus.dmem_ready;
    if (frozen) begin
      e.stall = 1'b1; e.to_wait = 1'b1;
    end else if (bus.ex_valid && (bus.ex_br_taken || bus.ex_jump)) begin
      e.pc_sel = 2'd1; e.pc_we = 1'b1; e.ifid_we = 1'b1; e.idex_we = 1'b1;
      e.if_flush = 1'b1; e.id_flush = 1'b1; e.redir = 1'b1;
    end else if (model_hazard()) begin
      e.idex_we = 1'b1; e.id_flush = 1'b1; e.stall = 1'b1;
    end else begin
      e.pc_we = 1'b1; e.ifid_we = 1'b1; e.idex_we = 1'b1;
    end
    return e;
  endfunction

  // Model state advance on the same edge as the DUT.
  always @(posedge clk) begin : model_update
    exp_t e;
    e = model_ctrl();
    if (rst) begin
      m_ready     <= 1'b1;
      m_mode      <= MBoot;
      m_boot_done <= 0;
      m_stall     <= 32'd0;
      m_redir     <= 32'd0;
    end else if (m_ready) begin
      if (m_mode == MBoot) begin
        m_boot_done <= m_boot_done + 1;
        if (m_boot_done + 1 >= int'(BootCycles)) m_mode <= MRun;
      end else begin
        m_stall <= m_stall + {31'd0, e.stall};
        m_redir <= m_redir + {31'd0, e.redir};
        m_mode  <= e.to_wait ? MWait : MRun;
      end
    end
  end

  always @(negedge clk) begin : compare
    exp_t e;
    if (m_ready) begin
      e = model_ctrl();
      check("imm_sel", {29'd0, bus.imm_sel}, {29'd0, model_imm(bus.id_inst[6:0])});
      check("illegal", {31'd0, bus.illegal},
            {31'd0, bus.id_valid && !model_is_base(bus.id_inst[6:0])});
      check("pc_sel", {30'd0, bus.pc_sel}, {30'd0, e.pc_sel});
      check("enables", {29'd0, bus.pc_we, bus.ifid_we, bus.idex_we},
            {29'd0, e.pc_we, e.ifid_we, e.idex_we});
      check("flushes", {30'd0, bus.if_flush, bus.id_flush}, {30'd0, e.if_flush, e.id_flush});
      check("stall_cnt", bus.stall_cnt, m_stall);
      check("redir_cnt", bus.redir_cnt, m_redir);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_inst     = 32'h0000_0013;
    bus.id_valid    = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_is_load  = 1'b0;
    bus.ex_br_taken = 1'b0;
    bus.ex_jump     = 1'b0;
    bus.dmem_req    = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  logic [6:0] sweep_op  [6] = '{7'b1100111, 7'b0100011, 7'b1100011, 7'b0010111, 7'b1101111,
                                7'b0001111};
  logic [2:0] sweep_imm [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
  logic       sweep_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                                7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

  initial begin
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Boot window then first RUN cycle
    for (int i = 0; i < int'(BootCycles); i++) begin
      #1;
      check("boot_pc_sel", {30'd0, bus.pc_sel}, 32'd2);
      check("boot_pc_we", {31'd0, bus.pc_we}, 32'd1);
      tick();
    end
    #1;
    check("run_pc_sel", {30'd0, bus.pc_sel}, 32'd0);
    check("run_enables", {29'd0, bus.pc_we, bus.ifid_we, bus.idex_we}, 32'd7);
    check("run_stall0", bus.stall_cnt, 32'd0);

    // Immediate-format sweep
    bus.id_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.id_inst = {25'd0, sweep_op[i]};
      #1;
      check("sweep_imm", {29'd0, bus.imm_sel}, {29'd0, sweep_imm[i]});
      check("sweep_ill", {31'd0, bus.illegal}, {31'd0, sweep_ill[i]});
    end
    bus.id_valid = 1'b0;
    #1;
    check("ill_invalid", {31'd0, bus.illegal}, 32'd0);
    tick();

    // Load-use hazard
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
    bus.id_valid = 1'b1; bus.id_inst = AddX1X5X2;
    #1;
    check("lu_enables", {29'd0, bus.pc_we, bus.ifid_we, bus.idex_we}, 32'd1);
    check("lu_flushes", {30'd0, bus.if_flush, bus.id_flush}, 32'd1);
    tick();
    bus.ex_valid = 1'b0;
    #1;
    check("lu_stall1", bus.stall_cnt, 32'd1);
    check("lu_released", {31'd0, bus.pc_we}, 32'd1);
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd0;
    #1;
    check("lu_x0", {31'd0, bus.pc_we}, 32'd1);
    bus.ex_rd = 5'd5; bus.id_inst = LuiX5;
    #1;
    check("lu_lui", {31'd0, bus.pc_we}, 32'd1);
    tick();
    check("lu_stall_still1", bus.stall_cnt, 32'd1);

    // Memory wait
    idle();
    bus.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mw_frozen", {29'd0, bus.pc_we, bus.ifid_we, bus.idex_we}, 32'd0);
      tick();
    end
    bus.dmem_ready = 1'b1;
    #1;
    check("mw_release", {29'd0, bus.pc_we, bus.ifid_we, bus.idex_we}, 32'd7);
    tick();
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
    #1;
    check("mw_back_run", {31'd0, bus.pc_we}, 32'd1);
    check("mw_stall5", bus.stall_cnt, 32'd5);

    // Redirect together with hazard
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
    bus.id_valid = 1'b1; bus.id_inst = AddX1X5X2; bus.ex_br_taken = 1'b1;
    #1;
    check("rd_pc_sel", {30'd0, bus.pc_sel}, 32'd1);
    check("rd_flushes", {30'd0, bus.if_flush, bus.id_flush}, 32'd3);
    check("rd_pc_we", {31'd0, bus.pc_we}, 32'd1);
    tick();
    idle();
    #1;
    check("rd_cnt1", bus.redir_cnt, 32'd1);
    check("rd_stall5", bus.stall_cnt, 32'd5);

    // Reset while frozen in MEM_WAIT
    bus.dmem_req = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_pc_sel", {30'd0, bus.pc_sel}, 32'd2);
    check("rst_stall0", bus.stall_cnt, 32'd0);
    check("rst_redir0", bus.redir_cnt, 32'd0);

    // Randomized traffic; the compare process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst             = ($urandom_range(0, 149) == 0);
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.ex_valid    = ($urandom_range(0, 3) != 0);
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.ex_is_load  = ($urandom_range(0, 2) == 0);
      bus.ex_br_taken = ($urandom_range(0, 7) == 0);
      bus.ex_jump     = ($urandom_range(0, 15) == 0);
      bus.dmem_req    = ($urandom_range(0, 3) == 0);
      bus.dmem_ready  = ($urandom_range(0, 1) == 0);
      bus.id_inst     = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         3'($urandom), 5'($urandom),
                         ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 8)]
                                                    : 7'($urandom)};
    end
    tick();
    idle();
    rst = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
